// File: rtl/mult_div_pkg.sv
// Shared types and sizing helpers for the multiply/divide unit.
package mult_div_pkg;

    // Sequencer states: idle, Booth multiply, restoring divide, result retire.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Iteration counter width for a given operand width: $clog2(WIDTH+1).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next
// dividend bit into the remainder, trial-subtract the divisor, and keep the
// difference only when it did not go negative.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // Shift, trial-subtract, restore on borrow; quotient bit is the inverted borrow.
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        trial   = shifted - {2'b00, divisor};
        if (trial[WIDTH+1]) begin
            rem_out = shifted[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end else begin
            rem_out = trial[WIDTH:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring on
// magnitudes with a final sign fix) feeding the HI/LO registers.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;

    // Booth accumulator carries one guard bit so that subtracting the most
    // negative multiplicand cannot overflow before the arithmetic shift.
    logic signed [WIDTH:0] acc;
    logic signed [WIDTH:0] m_ext;
    logic signed [WIDTH:0] booth_sum;
    logic [WIDTH-1:0] q;       // Booth multiplier Q, or dividend/quotient shifter
    logic             q_m1;
    logic [WIDTH-1:0] m;       // multiplicand, or divisor magnitude
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             op_mult;
    logic             quo_neg;
    logic             rem_neg;
    logic             dz_pend;
    logic [WIDTH-1:0] hi_fin;
    logic [WIDTH-1:0] lo_fin;

    // Two's-complement negate when the flag is set (also used for magnitudes).
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    div_restore_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  (rem),
        .quo_in  (q),
        .divisor (m),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mult_start)
                    state_nxt = MULT;
                else if (div_start)
                    state_nxt = (b == '0) ? FINISH : DIV;
            end
            MULT, DIV: begin
                if (cnt == LAST_ITER)
                    state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth add/subtract selection and signed result fix-up for retirement.
    always_comb begin
        m_ext = signed'({m[WIDTH-1], m});
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        if (op_mult) begin
            hi_fin = acc[WIDTH-1:0];
            lo_fin = q;
        end else begin
            hi_fin = neg_if(rem[WIDTH-1:0], rem_neg);
            lo_fin = neg_if(q, quo_neg);
        end
    end

    // All state, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            q_m1     <= 1'b0;
            m        <= '0;
            rem      <= '0;
            op_mult  <= 1'b0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            dz_pend  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mult_start || div_start) begin
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        cnt      <= '0;
                        op_mult  <= mult_start;
                        dz_pend  <= !mult_start && (b == '0);
                        quo_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
                        rem_neg  <= a[WIDTH-1];
                        acc      <= '0;
                        q_m1     <= 1'b0;
                        rem      <= '0;
                        if (mult_start) begin
                            q <= b;
                            m <= a;
                        end else begin
                            q <= neg_if(a, a[WIDTH-1]);
                            m <= neg_if(b, b[WIDTH-1]);
                        end
                    end
                end
                MULT: begin
                    acc  <= booth_sum >>> 1;
                    q    <= {booth_sum[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    cnt  <= cnt + CNT_W'(1);
                end
                DIV: begin
                    rem <= rem_nxt;
                    q   <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (dz_pend) begin
                        div_zero <= 1'b1;
                    end else begin
                        hi <= hi_fin;
                        lo <= lo_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed results.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mult_start = 1'b0;
    logic         div_start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcyc;
    int ndone;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Issue one request, then count edges until done (bounded) and busy cycles.
    task automatic do_op(input logic ms, input logic ds, input logic [W-1:0] av,
                         input logic [W-1:0] bv, output int lat_o, output int busy_o);
        @(negedge clk);
        mult_start = ms;
        div_start  = ds;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        lat_o  = 0;
        busy_o = busy ? 1 : 0;
        while (!done && lat_o < 100) begin
            @(posedge clk);
            #1;
            lat_o++;
            if (busy) busy_o++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi",   64'(hi),       64'(0));
        chk("rst_lo",   64'(lo),       64'(0));
        chk("rst_busy", 64'(busy),     64'(0));
        chk("rst_done", 64'(done),     64'(0));
        chk("rst_dz",   64'(div_zero), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // 7 * -3 = -21
        do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat, bcyc);
        chk("m1_lat",  64'(lat),  64'(33));
        chk("m1_busy", 64'(bcyc), 64'(33));
        chk("m1_hi",   64'(hi),   64'hFFFF_FFFF);
        chk("m1_lo",   64'(lo),   64'hFFFF_FFEB);
        @(posedge clk);
        #1;
        chk("m1_pulse", 64'(done), 64'(0));

        // (-2^31)^2 = 2^62
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, bcyc);
        chk("m2_hi", 64'(hi), 64'h4000_0000);
        chk("m2_lo", 64'(lo), 64'h0000_0000);

        // (2^31-1)^2 = 0x3FFFFFFF_00000001
        do_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bcyc);
        chk("m3_hi", 64'(hi), 64'h3FFF_FFFF);
        chk("m3_lo", 64'(lo), 64'h0000_0001);

        // -7 / 2 -> q=-3, r=-1
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
        chk("d1_lat", 64'(lat), 64'(33));
        chk("d1_lo",  64'(lo),  64'hFFFF_FFFD);
        chk("d1_hi",  64'(hi),  64'hFFFF_FFFF);

        // -2^31 / -1 wraps to -2^31, remainder 0
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
        chk("d2_lo", 64'(lo), 64'h8000_0000);
        chk("d2_hi", 64'(hi), 64'h0000_0000);

        // 100 / -7 -> q=-14, r=2
        do_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, lat, bcyc);
        chk("d3_lo", 64'(lo), 64'hFFFF_FFF2);
        chk("d3_hi", 64'(hi), 64'h0000_0002);

        // 0x02469234 / 0x2000 -> q=0x1234, r=0x1234
        do_op(1'b0, 1'b1, 32'h0246_9234, 32'h0000_2000, lat, bcyc);
        chk("d4_lo", 64'(lo), 64'h0000_1234);
        chk("d4_hi", 64'(hi), 64'h0000_1234);

        // 5 / 0: early finish, flag set, HI/LO untouched
        do_op(1'b0, 1'b1, 32'd5, 32'd0, lat, bcyc);
        chk("dz_lat",  64'(lat),      64'(1));
        chk("dz_busy", 64'(bcyc),     64'(1));
        chk("dz_flag", 64'(div_zero), 64'(1));
        chk("dz_lo",   64'(lo),       64'h0000_1234);
        chk("dz_hi",   64'(hi),       64'h0000_1234);

        // -5 * 6 = -30; also clears div_zero
        do_op(1'b1, 1'b0, 32'hFFFF_FFFB, 32'd6, lat, bcyc);
        chk("m4_dz", 64'(div_zero), 64'(0));
        chk("m4_hi", 64'(hi),       64'hFFFF_FFFF);
        chk("m4_lo", 64'(lo),       64'hFFFF_FFE2);

        // Both starts: multiply wins; a div_start while busy is dropped
        @(negedge clk);
        mult_start = 1'b1;
        div_start  = 1'b1;
        a = 32'd3;
        b = 32'd4;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        div_start = 1'b1;
        a = 32'd100;
        b = 32'd7;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        ndone = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("both_ndone", 64'(ndone), 64'(1));
        chk("both_lo",    64'(lo),    64'd12);
        chk("both_hi",    64'(hi),    64'd0);

        // Reset sampled on iteration edge 10 aborts the multiply
        @(negedge clk);
        mult_start = 1'b1;
        a = 32'd5;
        b = 32'd6;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ra_busy", 64'(busy), 64'(0));
        chk("ra_hi",   64'(hi),   64'(0));
        chk("ra_lo",   64'(lo),   64'(0));
        chk("ra_done", 64'(done), 64'(0));
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("ra_nodone", 64'(ndone), 64'(0));

        // Fresh multiply after the abort
        do_op(1'b1, 1'b0, 32'd2, 32'd2, lat, bcyc);
        chk("m5_lat", 64'(lat), 64'(33));
        chk("m5_lo",  64'(lo),  64'd4);
        chk("m5_hi",  64'(hi),  64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
